// File: rtl/piso_bit_serializer.sv
// rtl/piso_bit_serializer.sv - parallel-in serial-out stage feeding the 101 sequence detector
// Words are accepted on a valid/ready handshake and shifted out one bit per clock, gaplessly.
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRELAST_IDX  = CW'(WIDTH - 2);
    localparam logic [CNT_W-1:0] FRAMES_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_last_q, ser_last_d;
    logic [CNT_W-1:0] frames_q, frames_d;

    logic last_bit;
    logic accept;
    logic load_head;
    logic [WIDTH-1:0] load_rest;
    logic shreg_head;
    logic [WIDTH-1:0] shreg_rest;

    // The register holds the bits still to be sent, with the next one at the transmit end.
    always_comb begin
        if (MSB_FIRST) begin
            load_head  = load_data[WIDTH-1];
            load_rest  = {load_data[WIDTH-2:0], 1'b0};
            shreg_head = shreg_q[WIDTH-1];
            shreg_rest = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            load_head  = load_data[0];
            load_rest  = {1'b0, load_data[WIDTH-1:1]};
            shreg_head = shreg_q[0];
            shreg_rest = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign load_ready = reset && ((state_q == IDLE) || last_bit);
    assign accept     = load_valid && load_ready;
    assign busy       = (state_q == SHIFT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        frames_d    = frames_q;

        if (accept) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            shreg_d     = load_rest;
            ser_out_d   = load_head;
            ser_valid_d = 1'b1;
            ser_first_d = 1'b1;
        end else if ((state_q == SHIFT) && !last_bit) begin
            cnt_d       = cnt_q + CW'(1);
            shreg_d     = shreg_rest;
            ser_out_d   = shreg_head;
            ser_valid_d = 1'b1;
            ser_last_d  = (cnt_q == PRELAST_IDX);
        end else if (last_bit) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end

        // Count on the edge that retires the last bit; saturate rather than wrap.
        if (last_bit && (frames_q != FRAMES_MAX)) begin
            frames_d = frames_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            frames_q    <= frames_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign ser_first   = ser_first_q;
    assign ser_last    = ser_last_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb/tb_piso_bit_serializer.sv - directed self-checking bench for piso_bit_serializer
module tb_piso_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // MSB-first, 8-bit counter
    logic       rst_m, lv_m, lr_m, so_m, sv_m, sf_m, sl_m, bz_m;
    logic [7:0] ld_m, fs_m;
    // LSB-first, 8-bit counter
    logic       rst_l, lv_l, lr_l, so_l, sv_l, sf_l, sl_l, bz_l;
    logic [7:0] ld_l, fs_l;
    // MSB-first, 2-bit counter
    logic       rst_c, lv_c, lr_c, so_c, sv_c, sf_c, sl_c, bz_c;
    logic [7:0] ld_c;
    logic [1:0] fs_c;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(8)) dut_m (
        .clk(clk), .reset(rst_m), .load_data(ld_m), .load_valid(lv_m), .load_ready(lr_m),
        .ser_out(so_m), .ser_valid(sv_m), .ser_first(sf_m), .ser_last(sl_m),
        .busy(bz_m), .frames_sent(fs_m));

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(8)) dut_l (
        .clk(clk), .reset(rst_l), .load_data(ld_l), .load_valid(lv_l), .load_ready(lr_l),
        .ser_out(so_l), .ser_valid(sv_l), .ser_first(sf_l), .ser_last(sl_l),
        .busy(bz_l), .frames_sent(fs_l));

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(rst_c), .load_data(ld_c), .load_valid(lv_c), .load_ready(lr_c),
        .ser_out(so_c), .ser_valid(sv_c), .ser_first(sf_c), .ser_last(sl_c),
        .busy(bz_c), .frames_sent(fs_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_m = 1'b0; rst_l = 1'b0; rst_c = 1'b0;
        lv_m = 1'b0; lv_l = 1'b0; lv_c = 1'b0;
        ld_m = 8'h00; ld_l = 8'h00; ld_c = 8'h00;
        step();
        step();
        n_cmp++; if (so_m !== 1'b0) begin n_err++; $display("FAIL reset_ser_out got %b want 0", so_m); end
        n_cmp++; if (sv_m !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid got %b want 0", sv_m); end
        n_cmp++; if (sf_m !== 1'b0) begin n_err++; $display("FAIL reset_ser_first got %b want 0", sf_m); end
        n_cmp++; if (sl_m !== 1'b0) begin n_err++; $display("FAIL reset_ser_last got %b want 0", sl_m); end
        n_cmp++; if (bz_m !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bz_m); end
        n_cmp++; if (fs_m !== 8'd0) begin n_err++; $display("FAIL reset_frames got %0d want 0", fs_m); end
        n_cmp++; if (lr_m !== 1'b0) begin n_err++; $display("FAIL reset_load_ready_m got %b want 0", lr_m); end
        n_cmp++; if (lr_l !== 1'b0) begin n_err++; $display("FAIL reset_load_ready_l got %b want 0", lr_l); end
        n_cmp++; if (lr_c !== 1'b0) begin n_err++; $display("FAIL reset_load_ready_c got %b want 0", lr_c); end
        rst_m = 1'b1; rst_l = 1'b1; rst_c = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (so_m !== 1'b0) begin n_err++; $display("FAIL idle_ser_out[%0d] got %b want 0", i, so_m); end
            n_cmp++; if (sv_m !== 1'b0) begin n_err++; $display("FAIL idle_ser_valid[%0d] got %b want 0", i, sv_m); end
            n_cmp++; if (lr_m !== 1'b1) begin n_err++; $display("FAIL idle_load_ready[%0d] got %b want 1", i, lr_m); end
            n_cmp++; if (fs_m !== 8'd0) begin n_err++; $display("FAIL idle_frames[%0d] got %0d want 0", i, fs_m); end
            step();
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        seq = 8'b1100_0001;  // expected ser_out order, leftmost first
        ld_m = 8'hC1; lv_m = 1'b1;
        step();
        lv_m = 1'b0; ld_m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (so_m !== seq[7-i]) begin n_err++; $display("FAIL msb_bit[%0d] got %b want %b", i, so_m, seq[7-i]); end
            n_cmp++; if (sv_m !== 1'b1) begin n_err++; $display("FAIL msb_valid[%0d] got %b want 1", i, sv_m); end
            n_cmp++; if (sf_m !== (i == 0)) begin n_err++; $display("FAIL msb_first[%0d] got %b want %b", i, sf_m, (i == 0)); end
            n_cmp++; if (sl_m !== (i == 7)) begin n_err++; $display("FAIL msb_last[%0d] got %b want %b", i, sl_m, (i == 7)); end
            n_cmp++; if (bz_m !== 1'b1) begin n_err++; $display("FAIL msb_busy[%0d] got %b want 1", i, bz_m); end
            step();
        end
        n_cmp++; if (sv_m !== 1'b0) begin n_err++; $display("FAIL msb_end_valid got %b want 0", sv_m); end
        n_cmp++; if (so_m !== 1'b0) begin n_err++; $display("FAIL msb_end_ser_out got %b want 0", so_m); end
        n_cmp++; if (bz_m !== 1'b0) begin n_err++; $display("FAIL msb_end_busy got %b want 0", bz_m); end
        n_cmp++; if (fs_m !== 8'd1) begin n_err++; $display("FAIL msb_frames got %0d want 1", fs_m); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        seq = 8'b1000_0011;
        ld_l = 8'hC1; lv_l = 1'b1;
        step();
        lv_l = 1'b0; ld_l = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (so_l !== seq[7-i]) begin n_err++; $display("FAIL lsb_bit[%0d] got %b want %b", i, so_l, seq[7-i]); end
            n_cmp++; if (sv_l !== 1'b1) begin n_err++; $display("FAIL lsb_valid[%0d] got %b want 1", i, sv_l); end
            n_cmp++; if (sf_l !== (i == 0)) begin n_err++; $display("FAIL lsb_first[%0d] got %b want %b", i, sf_l, (i == 0)); end
            n_cmp++; if (sl_l !== (i == 7)) begin n_err++; $display("FAIL lsb_last[%0d] got %b want %b", i, sl_l, (i == 7)); end
            step();
        end
        n_cmp++; if (sv_l !== 1'b0) begin n_err++; $display("FAIL lsb_end_valid got %b want 0", sv_l); end
        n_cmp++; if (bz_l !== 1'b0) begin n_err++; $display("FAIL lsb_end_busy got %b want 0", bz_l); end
        n_cmp++; if (fs_l !== 8'd1) begin n_err++; $display("FAIL lsb_frames got %0d want 1", fs_l); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq;
        seq = 16'b1010_0101_0011_1100;
        ld_m = 8'hA5; lv_m = 1'b1;
        n_cmp++; if (lr_m !== 1'b1) begin n_err++; $display("FAIL b2b_idle_ready got %b want 1", lr_m); end
        step();
        ld_m = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (so_m !== seq[15-i]) begin n_err++; $display("FAIL b2b_bit[%0d] got %b want %b", i, so_m, seq[15-i]); end
            n_cmp++; if (sv_m !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b want 1", i, sv_m); end
            n_cmp++; if (sf_m !== (i == 0 || i == 8)) begin n_err++; $display("FAIL b2b_first[%0d] got %b want %b", i, sf_m, (i == 0 || i == 8)); end
            n_cmp++; if (lr_m !== (i == 7 || i == 15)) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want %b", i, lr_m, (i == 7 || i == 15)); end
            step();
            if (i == 7) begin
                lv_m = 1'b0; ld_m = 8'h00;
            end
        end
        n_cmp++; if (sv_m !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid got %b want 0", sv_m); end
        n_cmp++; if (fs_m !== 8'd3) begin n_err++; $display("FAIL b2b_frames got %0d want 3", fs_m); end
    endtask

    task automatic test_busy_reject_reset();
        ld_c = 8'h81; lv_c = 1'b1;
        step();
        lv_c = 1'b0; ld_c = 8'h00;
        step();
        step();
        ld_c = 8'hFF; lv_c = 1'b1;
        n_cmp++; if (lr_c !== 1'b0) begin n_err++; $display("FAIL busy_ready got %b want 0", lr_c); end
        step();
        n_cmp++; if (so_c !== 1'b0) begin n_err++; $display("FAIL busy_bit4 got %b want 0", so_c); end
        n_cmp++; if (sf_c !== 1'b0) begin n_err++; $display("FAIL busy_first got %b want 0", sf_c); end
        n_cmp++; if (sv_c !== 1'b1) begin n_err++; $display("FAIL busy_valid got %b want 1", sv_c); end
        lv_c = 1'b0; ld_c = 8'h00;
        step();
        n_cmp++; if (bz_c !== 1'b1) begin n_err++; $display("FAIL busy_bit5_busy got %b want 1", bz_c); end
        rst_c = 1'b0;
        step();
        n_cmp++; if (sv_c !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", sv_c); end
        n_cmp++; if (so_c !== 1'b0) begin n_err++; $display("FAIL midrst_ser_out got %b want 0", so_c); end
        n_cmp++; if (bz_c !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bz_c); end
        n_cmp++; if (fs_c !== 2'd0) begin n_err++; $display("FAIL midrst_frames got %0d want 0", fs_c); end
        n_cmp++; if (lr_c !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b want 0", lr_c); end
        rst_c = 1'b1;
        step();
        n_cmp++; if (lr_c !== 1'b1) begin n_err++; $display("FAIL postrst_ready got %b want 1", lr_c); end
        n_cmp++; if (fs_c !== 2'd0) begin n_err++; $display("FAIL postrst_frames got %0d want 0", fs_c); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_fs [5];
        exp_fs = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int f = 0; f < 5; f++) begin
            ld_c = 8'h5A; lv_c = 1'b1;
            step();
            lv_c = 1'b0;
            for (int b = 0; b < 8; b++) step();
            n_cmp++; if (fs_c !== exp_fs[f]) begin n_err++; $display("FAIL sat_frames[%0d] got %0d want %0d", f, fs_c, exp_fs[f]); end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_busy_reject_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
